// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//   Data-side memory bus between the single-cycle core and its memory responder.
//
//   Request (core -> responder):
//     MemWrite    store request this cycle
//     MemRead     load request this cycle
//     Funct3      RV32I load/store funct3 (size / extension)
//     ALUResult   byte address
//     WriteData   store data, right-aligned
//   Response (responder -> core / bench):
//     ReadData    load result, extended, combinational
//     MisalignErr sticky misaligned-access flag
//     ToHost      last value stored to the TOHOST register
//     ToHostValid sticky, set by the first TOHOST store
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MisalignErr;
    logic [31:0] ToHost;
    logic        ToHostValid;

    modport master (
        output MemWrite, MemRead, Funct3, ALUResult, WriteData,
        input  ReadData, MisalignErr, ToHost, ToHostValid
    );

    modport slave (
        input  MemWrite, MemRead, Funct3, ALUResult, WriteData,
        output ReadData, MisalignErr, ToHost, ToHostValid
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Data memory for the single-cycle RISC-V core: byte-addressed RAM with
//   sized/extended loads and lane-masked stores, plus a 16-byte MMIO window
//   holding a 64-bit cycle counter and the TOHOST bench-exit register.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset (RAM contents are not reset)
//     bus    data_mem_responder_if.slave (request in, ReadData/status out)
//
//   MMIO map (relative to MMIO_BASE):
//     +0x0 CYCLE_LO (ro)   +0x4 CYCLE_HI (ro)   +0x8 TOHOST (rw)   +0xC zero
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0F00
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] OFF_CYCLE_LO = 2'd0;
    localparam logic [1:0] OFF_CYCLE_HI = 2'd1;
    localparam logic [1:0] OFF_TOHOST   = 2'd2;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [63:0]   cycle_cnt;
    logic [31:0]   to_host;
    logic          to_host_valid;
    logic          misalign_err;

    logic [31:0]   addr;
    logic [AW-1:0] word_idx;
    logic          is_ram;
    logic          is_mmio;
    logic          misaligned;
    logic          store_ok;
    logic          ram_we;
    logic          to_host_we;

    logic [31:0]   mmio_word;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_ext;
    logic [3:0]    wmask;
    logic [31:0]   wword;

    // ---------------- address decode ----------------
    assign addr     = bus.ALUResult;
    assign word_idx = addr[AW+1:2];
    assign is_ram   = (addr < RAM_BYTES);
    assign is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; only counts while the
    // core is actually accessing memory.
    assign misaligned = (bus.MemRead || bus.MemWrite) &&
                        ((((bus.Funct3 == F3_H) || (bus.Funct3 == F3_HU)) && addr[0]) ||
                         ((bus.Funct3 == F3_W) && (addr[1:0] != 2'b00)));

    assign store_ok   = bus.MemWrite && !misaligned;
    // A store coinciding with an asserted reset is dropped.
    assign ram_we     = store_ok && is_ram && !reset;
    assign to_host_we = store_ok && is_mmio && (addr[3:2] == OFF_TOHOST) &&
                        (bus.Funct3 == F3_W);

    // ---------------- read path (combinational) ----------------
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it holding an old value (a latch).
    always_comb begin
        mmio_word = '0;
        case (addr[3:2])
            OFF_CYCLE_LO: mmio_word = cycle_cnt[31:0];
            OFF_CYCLE_HI: mmio_word = cycle_cnt[63:32];
            OFF_TOHOST:   mmio_word = to_host;
            default:      mmio_word = '0;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (is_ram) begin
            rd_word = mem[word_idx];
        end else if (is_mmio) begin
            rd_word = mmio_word;
        end

        rd_byte = rd_word[7:0];
        case (addr[1:0])
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

        rd_ext = '0;
        case (bus.Funct3)
            F3_B:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    rd_ext = {{16{rd_half[15]}}, rd_half};
            F3_W:    rd_ext = rd_word;
            F3_BU:   rd_ext = {24'b0, rd_byte};
            F3_HU:   rd_ext = {16'b0, rd_half};
            default: rd_ext = '0;
        endcase
    end

    assign bus.ReadData = misaligned ? 32'b0 : rd_ext;

    // ---------------- write path ----------------
    // Store data is replicated across all lanes; the mask picks which land.
    always_comb begin
        wmask = 4'b0000;
        wword = '0;
        case (bus.Funct3)
            F3_B: begin
                wmask = 4'b0001 << addr[1:0];
                wword = {4{bus.WriteData[7:0]}};
            end
            F3_H: begin
                wmask = addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{bus.WriteData[15:0]}};
            end
            F3_W: begin
                wmask = 4'b1111;
                wword = bus.WriteData;
            end
            default: begin
                wmask = 4'b0000;
                wword = '0;
            end
        endcase
    end

    // NOTE: the RAM array has no reset; clearing it would turn the block RAM
    // into a wide register file, and software never relies on its initial value.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    // ---------------- control/status registers ----------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt     <= '0;
            to_host       <= '0;
            to_host_valid <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (misaligned) begin
                misalign_err <= 1'b1;
            end
            if (to_host_we) begin
                to_host       <= bus.WriteData;
                to_host_valid <= 1'b1;
            end
        end
    end

    assign bus.MisalignErr = misalign_err;
    assign bus.ToHost      = to_host;
    assign bus.ToHostValid = to_host_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed stimulus drives the request bus on the falling edge and pushes
//   hand-computed expected values into a scoreboard queue; a monitor process
//   pops and compares them when the bench strobes a sample point, 2 ns after
//   the falling edge (well away from the rising edge).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
    localparam logic [31:0] MMIO = 32'h0000_0F00;

    localparam int SEL_RDATA = 0;
    localparam int SEL_MERR  = 1;
    localparam int SEL_TOH   = 2;
    localparam int SEL_TOHV  = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    event sample_ev;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (64),
        .MMIO_BASE   (MMIO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: drains the scoreboard at every sample strobe.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.sel)
                    SEL_RDATA: act = bus.ReadData;
                    SEL_MERR:  act = {31'b0, bus.MisalignErr};
                    SEL_TOH:   act = bus.ToHost;
                    default:   act = {31'b0, bus.ToHostValid};
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    task automatic access(input logic we, input logic re, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.MemWrite  = we;
        bus.MemRead   = re;
        bus.Funct3    = f3;
        bus.ALUResult = a;
        bus.WriteData = wd;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        sb_q.push_back('{name: name, sel: sel, exp: exp});
    endtask

    task automatic sample();
        #2;
        -> sample_ev;
        #1;
    endtask

    // Shorthands: load, store.
    task automatic ld(input logic [2:0] f3, input logic [31:0] a);
        access(1'b0, 1'b1, f3, a, 32'h0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        access(1'b1, 1'b0, f3, a, wd);
    endtask

    // Watchdog: the run is a fixed directed sequence; this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.Funct3    = 3'b000;
        bus.ALUResult = 32'h0;
        bus.WriteData = 32'h0;

        // Reset state.
        @(negedge clk);
        expect_val("rst_merr", SEL_MERR, 32'd0);
        expect_val("rst_toh",  SEL_TOH,  32'd0);
        expect_val("rst_tohv", SEL_TOHV, 32'd0);
        sample();
        @(negedge clk);
        reset = 1'b0;

        // Prime word 0x10, then store DEADBEEF with a same-cycle read.
        st(3'b010, 32'h10, 32'h0000_0000);
        access(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        expect_val("sw_same_cycle_old", SEL_RDATA, 32'h0000_0000);
        sample();
        ld(3'b010, 32'h10); expect_val("lw_10",  SEL_RDATA, 32'hDEAD_BEEF); sample();
        ld(3'b000, 32'h13); expect_val("lb_13",  SEL_RDATA, 32'hFFFF_FFDE); sample();
        ld(3'b100, 32'h13); expect_val("lbu_13", SEL_RDATA, 32'h0000_00DE); sample();
        ld(3'b001, 32'h10); expect_val("lh_10",  SEL_RDATA, 32'hFFFF_BEEF); sample();
        ld(3'b101, 32'h12); expect_val("lhu_12", SEL_RDATA, 32'h0000_DEAD); sample();
        ld(3'b000, 32'h11); expect_val("lb_11",  SEL_RDATA, 32'hFFFF_FFBE); sample();
        ld(3'b011, 32'h10); expect_val("ld_f3_011_zero", SEL_RDATA, 32'h0); sample();

        // Lane-masked stores: only the addressed bytes change.
        st(3'b000, 32'h11, 32'hAAAA_AA55);
        ld(3'b010, 32'h10); expect_val("sb_11", SEL_RDATA, 32'hDEAD_55EF); sample();
        st(3'b001, 32'h12, 32'hFFFF_1234);
        ld(3'b010, 32'h10); expect_val("sh_12", SEL_RDATA, 32'h1234_55EF); sample();
        st(3'b011, 32'h10, 32'h9999_9999);
        ld(3'b010, 32'h10); expect_val("st_f3_011_ignored", SEL_RDATA, 32'h1234_55EF); sample();

        // Last RAM word and first address past the RAM.
        st(3'b010, 32'hFC, 32'hCAFE_F00D);
        ld(3'b010, 32'hFC);  expect_val("lw_last_word", SEL_RDATA, 32'hCAFE_F00D); sample();
        ld(3'b010, 32'h100); expect_val("lw_past_ram",  SEL_RDATA, 32'h0);         sample();

        // Misalignment.
        ld(3'b010, 32'h10); expect_val("merr_before", SEL_MERR, 32'd0); sample();
        ld(3'b010, 32'h12); expect_val("lw_misaligned_zero", SEL_RDATA, 32'h0); sample();
        access(1'b1, 1'b0, 3'b001, 32'h11, 32'h0000_7777);
        expect_val("merr_after_lw", SEL_MERR, 32'd1);
        sample();
        ld(3'b010, 32'h10);
        expect_val("sh_misaligned_suppressed", SEL_RDATA, 32'h1234_55EF);
        expect_val("merr_sticky", SEL_MERR, 32'd1);
        sample();

        // Reset while a store is presented: store lost, flag cleared at once.
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h1111_1111);
        reset = 1'b1;
        expect_val("merr_async_clear", SEL_MERR, 32'd0);
        sample();
        @(negedge clk);
        reset = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b1;
        bus.Funct3    = 3'b010;
        bus.ALUResult = 32'h10;
        expect_val("store_lost_in_reset", SEL_RDATA, 32'h1234_55EF);
        sample();

        // Cycle counter: 10 rising edges after the release.
        repeat (10) @(posedge clk);
        ld(3'b010, MMIO + 32'h0); expect_val("cycle_lo_10", SEL_RDATA, 32'd10); sample();
        ld(3'b010, MMIO + 32'h4); expect_val("cycle_hi_0",  SEL_RDATA, 32'd0);  sample();

        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        ld(3'b010, MMIO + 32'h4); expect_val("cycle_hi_carry", SEL_RDATA, 32'd1); sample();
        ld(3'b010, MMIO + 32'h0); expect_val("cycle_lo_after", SEL_RDATA, 32'd1); sample();

        // TOHOST.
        st(3'b010, MMIO + 32'h8, 32'h0000_0001);
        expect_val("tohv_before_edge", SEL_TOHV, 32'd0);
        sample();
        st(3'b000, MMIO + 32'h8, 32'h0000_00FF);
        expect_val("toh_sw",  SEL_TOH,  32'd1);
        expect_val("tohv_sw", SEL_TOHV, 32'd1);
        sample();
        ld(3'b010, MMIO + 32'h8);
        expect_val("toh_sb_ignored", SEL_TOH,   32'd1);
        expect_val("lw_tohost",      SEL_RDATA, 32'd1);
        expect_val("sb_mmio_no_err", SEL_MERR,  32'd0);
        sample();
        ld(3'b010, MMIO + 32'hC); expect_val("lw_mmio_c", SEL_RDATA, 32'h0); sample();
        st(3'b010, MMIO + 32'hA, 32'h0000_0077);
        ld(3'b010, MMIO + 32'h8);
        expect_val("toh_misaligned_ignored", SEL_TOH,  32'd1);
        expect_val("merr_mmio_misaligned",   SEL_MERR, 32'd1);
        sample();

        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-side memory responder for the single-cycle RISC-V core.
- Consumes the datapath's memory-request outputs (ALUResult as address, WriteData, plus MemWrite/MemRead/Funct3 from control) and returns ReadData in the same cycle.
- Provides byte-addressed RAM with sized, extended loads and lane-masked stores.
- Also provides a small MMIO window: 64-bit cycle counter, TOHOST bench-exit register, sticky misalignment flag.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; power of two, at least 4.
- MMIO_BASE, 32'h0000_0F00, byte base of the MMIO window; 16-byte aligned; must lie at or above DEPTH_WORDS*4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  store request this cycle.
- MemRead  in  1  load request this cycle.
- Funct3  in  3  access size/extension (RV32I load/store funct3).
- ALUResult  in  32  byte address.
- WriteData  in  32  store data, right-aligned.
- ReadData  out  32  load result, extended; combinational.
- MisalignErr  out  1  sticky misaligned-access flag.
- ToHost  out  32  last value written to TOHOST.
- ToHostValid  out  1  sticky; set by the first TOHOST write.

Behaviour:
- Reset (async, immediate): MisalignErr=0, ToHost=0, ToHostValid=0, cycle counter=0. RAM contents are not reset. ReadData has no reset value; it follows its inputs combinationally.
- Address map:
  - RAM: addr < DEPTH_WORDS*4; word index = addr[log2(DEPTH_WORDS)+1:2].
  - MMIO +0x0 CYCLE_LO, read-only.
  - MMIO +0x4 CYCLE_HI, read-only.
  - MMIO +0x8 TOHOST, read/write.
  - MMIO +0xC and all other addresses: reads return 0, writes are ignored.
- Read path: combinational, zero-latency.
  - Byte/halfword lanes are selected by addr[1:0].
  - Funct3 000 LB sign-extend; 001 LH sign-extend; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend.
  - Funct3 011/110/111: ReadData=0.
  - When MemRead=0, ReadData still reflects the decoded address; the core ignores it.
- Write path: takes effect on the rising edge when MemWrite=1.
  - SB (000): WriteData[7:0] to lane addr[1:0].
  - SH (001): WriteData[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW (010): full word.
  - Other Funct3 values: no write.
- Misalignment:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, while MemRead or MemWrite is high.
  - The store is suppressed, ReadData=0, and MisalignErr is set on that edge. It stays set until reset.
- Cycle counter: 64 bits; increments every cycle while not in reset; wraps from 2^64-1 to 0. A read in cycle N returns the registered value.
- TOHOST:
  - Only SW updates it. On that edge ToHost<=WriteData and ToHostValid<=1 (sticky).
  - SB/SH to MMIO are ignored without an error.
  - Writes to CYCLE_LO/HI are ignored.
- Simultaneous MemWrite and MemRead: write proceeds; same-cycle ReadData shows pre-write contents. Read-after-write on the next cycle returns the new data.
- Reset asserted mid-store: the store is lost if reset is high at the edge. RAM is otherwise untouched.

Test Plan:
- SW 0xDEADBEEF to addr 0x10, next cycle LW 0x10 -> ReadData=0xDEADBEEF. Same-cycle read during the store -> prior contents.
- After that store: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF. SH 0x1234 to 0x12, then LW 0x10 -> 0x123455EF.
- LW 0x12 -> ReadData=0 and MisalignErr=1 after the edge. SH to 0x11 -> memory unchanged, flag stays 1. Reset -> MisalignErr=0.
- Release reset, wait 10 cycles, LW MMIO_BASE+0 -> 10 (±1 for sampling edge, fixed by bench), and MMIO_BASE+4 -> 0. Preload the counter to 0xFFFFFFFF via bench force -> CYCLE_HI=1 on the next cycle.
- SW 0x1 to MMIO_BASE+8 -> ToHost=1 and ToHostValid=1 after the edge. SB to the same address -> no change. LW MMIO_BASE+8 -> 1. LW MMIO_BASE+0xC -> 0.
